// File: rtl/wishbone_pkg.sv
// Shared Wishbone bus widths and arbiter state type.
package wishbone_pkg;

   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

   // Index width for n masters, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wishbone_interface.sv
// Classic Wishbone B4 signal bundle with master/slave views.
interface wishbone_interface;
   import wishbone_pkg::*;

   logic                cyc;
   logic                stb;
   logic                we;
   logic [WB_ADR_W-1:0] adr;
   logic [WB_SEL_W-1:0] sel;
   logic [WB_DAT_W-1:0] dat_mosi;
   logic [WB_DAT_W-1:0] dat_miso;
   logic                ack;
   logic                err;

   modport master (
      output cyc, stb, we, adr, sel, dat_mosi,
      input  dat_miso, ack, err
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_mosi,
      output dat_miso, ack, err
   );

endinterface

// File: rtl/wishbone_arb_pick.sv
// Combinational winner selection: round-robin after last_idx,
// or lowest index first when FIXED_PRIO is set.
module wishbone_arb_pick
   import wishbone_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter bit FIXED_PRIO  = 1'b0,
   localparam int IDX_W      = idx_width(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       last_idx,
   output logic [IDX_W-1:0]       winner,
   output logic                   any_req
);

   logic [IDX_W-1:0] cand;

   // Scan from lowest to highest priority so the last hit wins.
   always_comb begin
      winner  = '0;
      cand    = '0;
      any_req = |req;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         if (FIXED_PRIO)
            cand = IDX_W'(k - 1);
         else
            cand = IDX_W'((int'(last_idx) + k) % NUM_MASTERS);
         if (req[cand])
            winner = cand;
      end
   end

endmodule

// File: rtl/wishbone_arbiter.sv
// Multi-master Wishbone arbiter, one grant per cyc tenure.
// Define WISHBONE_ARBITER_FIXED_PRIORITY_EN for fixed priority.
module wishbone_arbiter
   import wishbone_pkg::*;
#(
   parameter int NUM_MASTERS = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   wishbone_interface.slave       masters [NUM_MASTERS],
   wishbone_interface.master      slave,
   output logic [NUM_MASTERS-1:0] grant
);

   localparam int IDX_W = idx_width(NUM_MASTERS);
`ifdef WISHBONE_ARBITER_FIXED_PRIORITY_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   arb_state_t             state;
   logic [IDX_W-1:0]       gnt_idx;
   logic [IDX_W-1:0]       last_idx;
   logic [IDX_W-1:0]       winner;
   logic                   any_req;
   logic                   busy;

   logic [NUM_MASTERS-1:0] m_cyc;
   logic [NUM_MASTERS-1:0] m_stb;
   logic [NUM_MASTERS-1:0] m_we;
   logic [WB_ADR_W-1:0]    m_adr [NUM_MASTERS];
   logic [WB_SEL_W-1:0]    m_sel [NUM_MASTERS];
   logic [WB_DAT_W-1:0]    m_dat [NUM_MASTERS];

   assign busy = (state == ARB_BUSY);

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
      logic own;
      assign own      = busy && (gnt_idx == IDX_W'(g));
      assign m_cyc[g] = masters[g].cyc;
      assign m_stb[g] = masters[g].stb;
      assign m_we[g]  = masters[g].we;
      assign m_adr[g] = masters[g].adr;
      assign m_sel[g] = masters[g].sel;
      assign m_dat[g] = masters[g].dat_mosi;

      assign masters[g].ack      = own && slave.ack;
      assign masters[g].err      = own && slave.err;
      assign masters[g].dat_miso = own ? slave.dat_miso : '0;
   end

   // Pass-through so slave.cyc falls in the owner's release cycle.
   assign slave.cyc      = busy && m_cyc[gnt_idx];
   assign slave.stb      = busy && m_stb[gnt_idx];
   assign slave.we       = busy && m_we[gnt_idx];
   assign slave.adr      = busy ? m_adr[gnt_idx] : '0;
   assign slave.sel      = busy ? m_sel[gnt_idx] : '0;
   assign slave.dat_mosi = busy ? m_dat[gnt_idx] : '0;

   wishbone_arb_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .FIXED_PRIO  (FIXED_PRIO)
   ) u_pick (
      .req      (m_cyc),
      .last_idx (last_idx),
      .winner   (winner),
      .any_req  (any_req)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ARB_IDLE;
         gnt_idx  <= '0;
         last_idx <= IDX_W'(NUM_MASTERS - 1);
         grant    <= '0;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (any_req) begin
                  state   <= ARB_BUSY;
                  gnt_idx <= winner;
                  grant   <= NUM_MASTERS'(1) << winner;
               end
            end
            ARB_BUSY: begin
               if (!m_cyc[gnt_idx]) begin
                  state    <= ARB_IDLE;
                  last_idx <= gnt_idx;
                  grant    <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter with four masters.
`timescale 1ns/1ps
module tb_wishbone_arbiter;
   import wishbone_pkg::*;

   localparam int N = 4;
   localparam logic [31:0] RD = 32'hDEAD_BEEF;
`ifdef WISHBONE_ARBITER_FIXED_PRIORITY_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [N-1:0] grant;
   logic [N-1:0] cyc, stb, we, ack_o, err_o;
   logic [31:0] adr [N];
   logic [3:0]  sel [N];
   logic [31:0] dmo [N];
   logic [31:0] dmi [N];
   logic        s_ack, s_err;
   logic [31:0] s_dmiso;

   int checks = 0;
   int failures = 0;
   int own;
   int last;

   wishbone_interface m [N] ();
   wishbone_interface s ();

   for (genvar g = 0; g < N; g++) begin : g_bind
      assign m[g].cyc      = cyc[g];
      assign m[g].stb      = stb[g];
      assign m[g].we       = we[g];
      assign m[g].adr      = adr[g];
      assign m[g].sel      = sel[g];
      assign m[g].dat_mosi = dmo[g];
      assign ack_o[g]      = m[g].ack;
      assign err_o[g]      = m[g].err;
      assign dmi[g]        = m[g].dat_miso;
   end

   assign s.ack      = s_ack;
   assign s.err      = s_err;
   assign s.dat_miso = s_dmiso;

   wishbone_arbiter #(.NUM_MASTERS(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .masters (m),
      .slave   (s),
      .grant   (grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: next owner from the request set and the previous owner.
   function automatic int pick(input logic [N-1:0] r, input int lst);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = FIXED ? (k - 1) : ((lst + k) % N);
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic step_check(input string tag);
      logic [N-1:0] eg, ea, ee;
      @(negedge clk);
      eg = (own >= 0) ? (N'(1) << own) : '0;
      ea = (own >= 0 && s_ack) ? eg : '0;
      ee = (own >= 0 && s_err) ? eg : '0;
      chk({tag, " grant"}, 32'(grant), 32'(eg));
      if (own >= 0) begin
         chk({tag, " s.cyc"}, 32'(s.cyc), 32'(cyc[own]));
         chk({tag, " s.stb"}, 32'(s.stb), 32'(stb[own]));
         chk({tag, " s.we"}, 32'(s.we), 32'(we[own]));
         chk({tag, " s.adr"}, s.adr, adr[own]);
         chk({tag, " s.sel"}, 32'(s.sel), 32'(sel[own]));
         chk({tag, " s.dat"}, s.dat_mosi, dmo[own]);
      end else begin
         chk({tag, " s.cyc idle"}, 32'(s.cyc), 32'd0);
         chk({tag, " s.stb idle"}, 32'(s.stb), 32'd0);
      end
      chk({tag, " ack"}, 32'(ack_o), 32'(ea));
      chk({tag, " err"}, 32'(err_o), 32'(ee));
      for (int i = 0; i < N; i++)
         chk({tag, " dat_miso"}, dmi[i], eg[i] ? s_dmiso : 32'd0);
      if (own < 0)
         own = pick(cyc, last);
      else if (!cyc[own]) begin
         last = own;
         own  = -1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc = '0; stb = '0; we = '0;
      s_ack = 1'b0; s_err = 1'b0; s_dmiso = RD;
      for (int i = 0; i < N; i++) begin
         adr[i] = 32'h1000 + 32'(i) * 32'h100;
         sel[i] = 4'hF;
         dmo[i] = 32'hA000_0000 + 32'(i);
      end
      #1;
      chk("reset grant", 32'(grant), 32'd0);
      chk("reset s.cyc", 32'(s.cyc), 32'd0);
      chk("reset s.adr", s.adr, 32'd0);
      chk("reset ack", 32'(ack_o), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst  = 1'b1;
      own  = -1;
      last = N - 1;
   endtask

   typedef struct packed {
      logic [N-1:0] cyc;
      logic         ack;
      logic [N-1:0] g;
      logic         scyc;
      logic [N-1:0] a;
   } vec_t;

   vec_t tbl [24];

   initial begin
      tbl[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[1]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000};
      tbl[2]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0001};
      tbl[3]  = '{4'b0010, 1'b1, 4'b0001, 1'b0, 4'b0001};
      tbl[4]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[5]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 4'b0010};
      tbl[6]  = '{4'b0001, 1'b0, 4'b0010, 1'b0, 4'b0000};
      tbl[7]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[8]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000};
      tbl[9]  = '{4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000};
      tbl[10] = '{4'b1010, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[11] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 4'b0000};
      tbl[12] = '{4'b1000, 1'b0, 4'b0010, 1'b0, 4'b0000};
      tbl[13] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[14] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 4'b0000};
      tbl[15] = '{4'b1010, 1'b0, 4'b1000, 1'b1, 4'b0000};
      tbl[16] = '{4'b0010, 1'b0, 4'b1000, 1'b0, 4'b0000};
      tbl[17] = '{4'b1010, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[18] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 4'b0000};
      tbl[19] = '{4'b1000, 1'b0, 4'b0010, 1'b0, 4'b0000};
      tbl[20] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[21] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 4'b1000};
      tbl[22] = '{4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0000};
      tbl[23] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};

      do_reset();
      for (int r = 0; r < 24; r++) begin
         cyc   = tbl[r].cyc;
         stb   = tbl[r].cyc;
         s_ack = tbl[r].ack;
         @(negedge clk);
         chk($sformatf("row%0d grant", r), 32'(grant), 32'(tbl[r].g));
         chk($sformatf("row%0d s.cyc", r), 32'(s.cyc), 32'(tbl[r].scyc));
         chk($sformatf("row%0d ack", r), 32'(ack_o), 32'(tbl[r].a));
         for (int i = 0; i < N; i++) begin
            chk($sformatf("row%0d dat_miso%0d", r, i), dmi[i],
                tbl[r].g[i] ? RD : 32'd0);
            if (tbl[r].g[i])
               chk($sformatf("row%0d s.adr", r), s.adr,
                   32'h1000 + 32'(i) * 32'h100);
         end
         @(posedge clk);
         #1;
      end

      // Two masters always requesting, 3-beat tenures each.
      begin : alt
         int beats [N];
         int wins [$];
         int gaps [$];
         int idle_run;
         logic [N-1:0] prev_g;
         do_reset();
         s_ack = 1'b1;
         prev_g = '0;
         idle_run = 0;
         for (int i = 0; i < N; i++) beats[i] = 0;
         for (int c = 0; c < 26; c++) begin
            for (int i = 0; i < 2; i++) begin
               cyc[i] = !(grant[i] && beats[i] == 3);
               stb[i] = cyc[i];
               if (!grant[i]) beats[i] = 0;
               else if (cyc[i]) beats[i]++;
            end
            if (grant == '0)
               idle_run++;
            else if (prev_g == '0) begin
               wins.push_back($clog2(grant));
               if (wins.size() > 1) gaps.push_back(idle_run);
               idle_run = 0;
            end
            prev_g = grant;
            step_check("alt");
         end
         chk("alt tenures", 32'(wins.size() >= 4), 32'd1);
         for (int k = 0; k < 4 && k < wins.size(); k++)
            chk($sformatf("alt winner%0d", k), 32'(wins[k]),
                FIXED ? 32'd0 : 32'(k % 2));
         foreach (gaps[k])
            chk($sformatf("alt gap%0d", k), 32'(gaps[k]), 32'd1);
         cyc = '0; stb = '0;
         step_check("alt end");
         step_check("alt end");
      end

      // Long tenure: master1 starves, timeout err goes to master0.
      do_reset();
      cyc = 4'b0011;
      stb = 4'b0011;
      for (int c = 0; c < 302; c++) begin
         s_err = (c == 256);
         step_check("hold");
      end
      cyc = '0; stb = '0;
      step_check("hold end");
      step_check("hold end");

      // Reset during a tenure, then both request again.
      do_reset();
      cyc = 4'b0001;
      stb = 4'b0001;
      step_check("rmid");
      step_check("rmid");
      chk("rmid busy before reset", 32'(grant), 32'd1);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rmid async s.cyc", 32'(s.cyc), 32'd0);
      chk("rmid async grant", 32'(grant), 32'd0);
      chk("rmid async ack", 32'(ack_o | err_o), 32'd0);
      cyc = 4'b0011;
      stb = 4'b0011;
      @(posedge clk);
      #1;
      rst  = 1'b1;
      own  = -1;
      last = N - 1;
      step_check("rmid rel");
      chk("rmid winner", 32'(grant), 32'd1);
      cyc = '0; stb = '0;
      step_check("rmid end");
      step_check("rmid end");

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) cyc[i] = ~cyc[i];
            stb[i] = cyc[i] & 1'($urandom_range(0, 1));
            we[i]  = 1'($urandom_range(0, 1));
            adr[i] = $urandom;
            sel[i] = 4'($urandom);
            dmo[i] = $urandom;
         end
         s_ack   = 1'($urandom_range(0, 1));
         s_err   = ($urandom_range(0, 15) == 0);
         s_dmiso = $urandom;
         step_check("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
- Multi-master Wishbone arbiter placed directly upstream of the address-decoding interconnect.
- Collects NUM_MASTERS master ports (CPU instruction fetch, CPU data, DMA, debug) and grants one of them the single downstream bus per bus tenure (one contiguous cyc assertion).
- Default policy is round-robin; a compile-time option selects fixed priority.
- Response signals (ack, err, dat_miso) are returned only to the granted master.

Parameters:
- NUM_MASTERS, 2, number of upstream masters (1..8); index 0 has highest tie-break priority.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- masters  wishbone_interface.slave  array[NUM_MASTERS]  upstream master ports (cyc, stb, adr[31:0], sel[3:0], we, dat_mosi[31:0] in; dat_miso[31:0], ack, err out).
- slave  wishbone_interface.master  1  downstream port to the interconnect.
- grant  output  NUM_MASTERS  one-hot current owner; all-zero when idle.

Behaviour:
- State machine states (registered): IDLE, BUSY. Registers: gnt_idx (clog2 width, min 1), last_idx.
- Reset (rst low, asynchronous): state=IDLE, gnt_idx=0, last_idx=NUM_MASTERS-1. Output values during reset:
  - slave.cyc/stb/we = 0; slave.adr/sel/dat_mosi = 0.
  - every masters[i].ack/err = 0 and masters[i].dat_miso = 0.
  - grant = 0.
- IDLE:
  - slave.cyc = 0, slave.stb = 0, grant = 0.
  - req[i] = masters[i].cyc.
  - If any req is set: winner = first set bit scanning last_idx+1, last_idx+2, … modulo NUM_MASTERS. Next cycle: gnt_idx=winner, state=BUSY.
  - If no req is set: remain in IDLE.
- BUSY (combinational forwarding):
  - slave.{cyc, stb, adr, sel, we, dat_mosi} = masters[gnt_idx].{…}.
  - masters[gnt_idx].{ack, err, dat_miso} = slave.{…}.
  - All other masters: ack = 0, err = 0, dat_miso = 0.
  - grant = one-hot(gnt_idx).
- BUSY -> IDLE when masters[gnt_idx].cyc = 0. slave.cyc drops in that same cycle (pass-through). last_idx <= gnt_idx.
- Arbitration latency: a request seen in IDLE at cycle N is forwarded downstream from cycle N+1. After a release there is at least one IDLE cycle before the next grant, so back-to-back tenures have a 1-cycle gap.
- No pre-emption: the granted master holds the bus for as long as cyc stays high, regardless of other requests. The downstream 255-cycle timeout err is forwarded unchanged.
- Ungranted masters may hold cyc/stb indefinitely. They receive no ack or err and their request stays pending.
- ack or err arriving in the same cycle the owner drops cyc: forwarded combinationally to the owner; the state still returns to IDLE.
- If the owner raises cyc again in the cycle directly after release, it competes normally. Round-robin places it last behind any other requester.
- Reset asserted mid-tenure: bus is released immediately. No ack or err is produced for the aborted transfer.
- NUM_MASTERS=1: same FSM; the IDLE gap still applies.

Optional Feature:
- Macro: WISHBONE_ARBITER_FIXED_PRIORITY_EN.
- Defined: the winner is always the lowest set index of req; last_idx is not used for selection (it may still be updated).
- Undefined: round-robin as specified above.
- All other timing is identical in both modes.

Decomposition:
- Shared package wishbone_pkg:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  - constants WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
- Sub-module wishbone_arb_pick (purely combinational):
  - inputs: req[NUM_MASTERS], last_idx, plus the fixed-priority mode.
  - outputs: winner index and any_req.
- The arbiter instantiates one wishbone_arb_pick and owns the FSM, registers and muxing.

Test Plan:
- Reset, then NUM_MASTERS=2 with master0 cyc/stb, adr=0x0000_1000, we=0 -> grant=01 one cycle later; slave.adr=0x1000; slave ack with dat_miso=0xDEAD_BEEF reaches only master0; master1 sees ack=0, dat_miso=0.
- Both masters hold cyc continuously with 3-beat tenures -> grants alternate 01,10,01,10 with exactly one IDLE cycle between tenures. With WISHBONE_ARBITER_FIXED_PRIORITY_EN, master0 wins every arbitration.
- Master1 requests while master0 holds cyc for 300 cycles -> master1 is never acked; grant stays 01; the timeout err at cycle 255 reaches master0 only.
- Owner drops cyc in the same cycle slave ack=1 -> ack delivered to owner; next cycle state IDLE and grant=0; slave.cyc=0 in the drop cycle.
- Assert rst low mid-tenure (master0 stb=1, no ack yet) -> slave.cyc=0 and grant=0 immediately without waiting for clk. After release with both masters requesting, master0 wins (last_idx reset to NUM_MASTERS-1).
- NUM_MASTERS=4, requests from masters 1 and 3 after master3's tenure -> master1 granted, then master3.
